// File: rtl/debounce_pkg.sv
// Shared defaults, counter-width helper and per-channel FSM state type
// for the switch debouncer.
package debounce_pkg;

    localparam int N_BITS_DEF        = 4;
    localparam int STABLE_CYCLES_DEF = 50000;

    // Counter must hold values up to STABLE_CYCLES without wrapping.
    function automatic int cnt_w(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/debounce_channel.sv
// One switch bit: 2-flop synchroniser, stability counter, IDLE/PENDING FSM,
// and registered level plus rise/fall strobes.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_out,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int               CW   = cnt_w(STABLE_CYCLES);
    localparam logic [CW-1:0]    LAST = CW'(STABLE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic          r_out;
    logic          r_rise;
    logic          r_fall;
    logic          w_mismatch;
    logic          w_accept;

    // With STABLE_CYCLES == 1 the first mismatching cycle already completes the count.
    always_comb begin
        w_mismatch = (r_sync2 != r_out);
        w_accept   = 1'b0;
        if (w_mismatch) begin
            if (r_state == IDLE)
                w_accept = (STABLE_CYCLES == 1);
            else
                w_accept = (r_cnt == LAST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others (the synchroniser chain depends on this).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (w_accept) begin
                r_out   <= r_sync2;
                r_rise  <= r_sync2;
                r_fall  <= ~r_sync2;
                r_cnt   <= '0;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_mismatch) begin
                            r_cnt   <= CW'(1);
                            r_state <= PENDING;
                        end
                    end
                    PENDING: begin
                        if (!w_mismatch) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sw_out = r_out;
    assign rise   = r_rise;
    assign fall   = r_fall;
    assign accept = w_accept;

endmodule

// File: rtl/switch_debouncer.sv
// N_BITS independent debounce channels; changed is registered from the channels'
// accept strobes so it lines up with rise/fall on the same edge.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int N_BITS        = N_BITS_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] sw_in,
    output logic [N_BITS-1:0] sw_out,
    output logic [N_BITS-1:0] rise,
    output logic [N_BITS-1:0] fall,
    output logic              changed
);

    logic [N_BITS-1:0] w_accept;
    logic              r_changed;

    for (genvar i = 0; i < N_BITS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .sw_in  (sw_in[i]),
            .sw_out (sw_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .accept (w_accept[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_changed <= 1'b0;
        else
            r_changed <= |w_accept;
    end

    assign changed = r_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES = 4 (update on edge 6).
module tb_switch_debouncer;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_in;
    logic [3:0] sw_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .N_BITS        (4),
        .STABLE_CYCLES (S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] v);
        rst   = 1'b1;
        sw_in = v;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_out, exp_rise;
        rst   = 1'b1;
        sw_in = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({sw_out, rise, fall, changed} !== 13'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got out=%b rise=%b fall=%b chg=%b want all 0",
                         i, sw_out, rise, fall, changed);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_out  = (e >= 6) ? 4'hF : 4'h0;
            exp_rise = (e == 6) ? 4'hF : 4'h0;
            checks++;
            if (sw_out !== exp_out || rise !== exp_rise || fall !== 4'h0 || changed !== (e == 6)) begin
                errors++;
                $display("FAIL reset_release edge%0d: got out=%b rise=%b fall=%b chg=%b want out=%b rise=%b fall=0000 chg=%b",
                         e, sw_out, rise, fall, changed, exp_out, exp_rise, (e == 6));
            end
        end
    endtask

    task automatic test_clean_step();
        logic [3:0] exp_out, exp_rise;
        apply_reset(4'h0);
        for (int i = 0; i < 3; i++) tick();
        sw_in = 4'b1010;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_out  = (e >= 6) ? 4'b1010 : 4'h0;
            exp_rise = (e == 6) ? 4'b1010 : 4'h0;
            checks++;
            if (sw_out !== exp_out || rise !== exp_rise || fall !== 4'h0 || changed !== (e == 6)) begin
                errors++;
                $display("FAIL clean_step edge%0d: got out=%b rise=%b fall=%b chg=%b want out=%b rise=%b fall=0000 chg=%b",
                         e, sw_out, rise, fall, changed, exp_out, exp_rise, (e == 6));
            end
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        apply_reset(4'h0);
        tick();
        sw_in = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 2) sw_in = 4'h0;
            if (sw_out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || changed !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL glitch: got %0d cycles with output activity, want 0", bad);
        end
    endtask

    task automatic test_bounce();
        int rise_cnt, rise_edge, stray, e;
        rise_cnt = 0; rise_edge = -1; stray = 0; e = 0;
        apply_reset(4'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            sw_in[2] = ((i / 2) % 2 == 0);
            if (i >= 8) e++;
            tick();
            if (rise[2] === 1'b1) begin
                rise_cnt++;
                rise_edge = e;
            end
            if (fall !== 4'h0 || rise[3] !== 1'b0 || rise[1:0] !== 2'b00) stray++;
        end
        for (int k = 0; k < 12; k++) begin
            e++;
            tick();
            if (rise[2] === 1'b1) begin
                rise_cnt++;
                rise_edge = e;
            end
            if (fall !== 4'h0 || rise[3] !== 1'b0 || rise[1:0] !== 2'b00) stray++;
        end
        checks++;
        if (rise_cnt !== 1) begin
            errors++;
            $display("FAIL bounce_rise_count: got %0d want 1", rise_cnt);
        end
        checks++;
        if (rise_edge !== 6) begin
            errors++;
            $display("FAIL bounce_rise_edge: got %0d want 6", rise_edge);
        end
        checks++;
        if (sw_out !== 4'b0100 || stray !== 0) begin
            errors++;
            $display("FAIL bounce_final: got out=%b stray=%0d want out=0100 stray=0", sw_out, stray);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_out, exp_rise, exp_fall;
        apply_reset(4'h0);
        tick();
        sw_in = 4'b0010;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (sw_out !== 4'b0010) begin
            errors++;
            $display("FAIL simul_setup: got out=%b want 0010", sw_out);
        end
        sw_in = 4'b1000;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_out  = (e >= 6) ? 4'b1000 : 4'b0010;
            exp_rise = (e == 6) ? 4'b1000 : 4'h0;
            exp_fall = (e == 6) ? 4'b0010 : 4'h0;
            checks++;
            if (sw_out !== exp_out || rise !== exp_rise || fall !== exp_fall || changed !== (e == 6)) begin
                errors++;
                $display("FAIL simultaneous edge%0d: got out=%b rise=%b fall=%b chg=%b want out=%b rise=%b fall=%b chg=%b",
                         e, sw_out, rise, fall, changed, exp_out, exp_rise, exp_fall, (e == 6));
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [3:0] exp_out, exp_rise;
        apply_reset(4'h0);
        tick();
        sw_in = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({sw_out, rise, fall, changed} !== 13'd0) begin
            errors++;
            $display("FAIL midcount_async: got out=%b rise=%b fall=%b chg=%b want all 0",
                     sw_out, rise, fall, changed);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_out  = (e >= 6) ? 4'b1000 : 4'h0;
            exp_rise = (e == 6) ? 4'b1000 : 4'h0;
            checks++;
            if (sw_out !== exp_out || rise !== exp_rise || fall !== 4'h0 || changed !== (e == 6)) begin
                errors++;
                $display("FAIL midcount_release edge%0d: got out=%b rise=%b fall=%b chg=%b want out=%b rise=%b fall=0000 chg=%b",
                         e, sw_out, rise, fall, changed, exp_out, exp_rise, (e == 6));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        sw_in = 4'h0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
